// File: rtl/trans_source.sv
// trans_source: transmit side of the 128-bit transaction interface.
// Assembles 16 bytes (MSB byte first) into a 128-bit transaction word.
// Completed words go into a small FIFO. The FIFO head is presented on
// data_o/valid_o and is held there until the validator acknowledges it.
//
// Word layout:
//   [127:80] sender id
//   [79:32]  receiver id
//   [31:10]  amount
//   [9]      block start
//   [8:0]    reserved
//
// Ports:
//   clk, rst      single clock; synchronous active-high reset
//   byte_i        input byte
//   byte_valid_i  byte_i is valid this cycle
//   byte_ready_o  byte is accepted when byte_valid_i & byte_ready_o
//   abort_i       discard the partially assembled word
//   data_o        head-of-FIFO transaction word
//   valid_o       data_o holds a pending word
//   ack_i         validator accepted data_o; pops the FIFO
//   count_o       words acknowledged since reset (wraps at 2^16)
//   overflow_o    sticky: a byte was offered while byte_ready_o=0
//   dbg_state     1 while the assembler is in STALL, 0 in COLLECT
//
// Handshakes:
//   Byte side: a byte transfers on a clock edge where byte_valid_i and
//   byte_ready_o are both 1 and abort_i is 0. The sender must not raise
//   byte_valid_i while byte_ready_o=0. A byte offered that way is dropped
//   and latches overflow_o.
//   Word side: valid_o/data_o stay stable until an edge with ack_i=1.
//   At that edge the word is popped. An ack_i while valid_o=0 is ignored.
module trans_source #(
  parameter int FIFO_DEPTH   = 4,
  parameter int BYTES_PER_TX = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   byte_i,
  input  logic         byte_valid_i,
  output logic         byte_ready_o,
  input  logic         abort_i,
  output logic [127:0] data_o,
  output logic         valid_o,
  input  logic         ack_i,
  output logic [15:0]  count_o,
  output logic         overflow_o,
  output logic         dbg_state
);

  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  BC_LAST = 4'(BYTES_PER_TX - 1);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  typedef enum logic {COLLECT = 1'b0, STALL = 1'b1} state_e;

  state_e       state;
  logic [3:0]   bc;
  // Only the 15 most recent bytes are kept. The 16th byte goes straight
  // into the FIFO word.
  logic [119:0] sr;
  logic [127:0] mem [FIFO_DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;

  logic         fifo_empty, fifo_full;
  logic         accept, push, pop;
  logic [3:0]   bc_n;
  logic [AW:0]  wr_ptr_n, rd_ptr_n;
  logic         full_n;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Readiness is computed from the registered full flag. A pop in the same
  // cycle does not open the slot until the next cycle.
  assign byte_ready_o = !rst && !(bc == BC_LAST && fifo_full);

  assign accept = byte_valid_i && byte_ready_o && !abort_i;
  assign push   = accept && (bc == BC_LAST);
  assign pop    = ack_i && !fifo_empty;

  assign valid_o   = !fifo_empty;
  assign data_o    = mem[rd_ptr[AW-1:0]];
  assign dbg_state = (state == STALL);

  always_comb begin
    bc_n     = bc;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    if (abort_i)     bc_n = 4'd0;
    else if (accept) bc_n = bc + 4'd1;
    if (push) wr_ptr_n = wr_ptr + PTR_ONE;
    if (pop)  rd_ptr_n = rd_ptr + PTR_ONE;
    full_n = (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
             (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      bc         <= 4'd0;
      sr         <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= 16'd0;
      overflow_o <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      bc     <= bc_n;
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      state  <= (bc_n == BC_LAST && full_n) ? STALL : COLLECT;
      if (accept) sr <= {sr[111:0], byte_i};
      if (push)   mem[wr_ptr[AW-1:0]] <= {sr, byte_i};
      if (pop)    count_o <= count_o + 16'd1;
      if (byte_valid_i && !byte_ready_o) overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_trans_source.sv
module tb_trans_source;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   byte_i;
  logic         byte_valid_i;
  logic         byte_ready_o;
  logic         abort_i;
  logic [127:0] data_o;
  logic         valid_o;
  logic         ack_i;
  logic [15:0]  count_o;
  logic         overflow_o;
  logic         dbg_state;

  trans_source #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .byte_ready_o(byte_ready_o), .abort_i(abort_i), .data_o(data_o),
    .valid_o(valid_o), .ack_i(ack_i), .count_o(count_o),
    .overflow_o(overflow_o), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q[$];
  logic [15:0]  exp_count = 16'd0;

  typedef struct {
    logic [7:0]   base;
    logic [7:0]   step;
    logic [127:0] exp_word;
  } vec_t;
  vec_t vecs[5];

  // ---------------- check / driver tasks ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] make_word(input logic [7:0] base, input logic [7:0] step);
    logic [127:0] w;
    logic [7:0] b;
    w = '0;
    b = base;
    for (int k = 0; k < 16; k++) begin
      w = {w[119:0], b};
      b = b + step;
    end
    return w;
  endfunction

  // Inputs change at negedge, so the DUT samples them at the next posedge.
  // Outputs are checked at the following negedge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    while (!byte_ready_o && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      checks++;
      failures++;
      $display("FAIL byte_ready_timeout: byte_ready_o stayed 0 for %0d cycles", n);
    end
    byte_i = b;
    byte_valid_i = 1'b1;
    @(negedge clk);
    byte_valid_i = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] base, input logic [7:0] step, input int cnt);
    logic [7:0] b;
    b = base;
    for (int k = 0; k < cnt; k++) begin
      send_byte(b);
      b = b + step;
    end
  endtask

  task automatic send_word(input logic [7:0] base, input logic [7:0] step);
    send_bytes(base, step, 16);
    exp_q.push_back(make_word(base, step));
  endtask

  task automatic ack_and_check(input string name);
    logic [127:0] e;
    check({name, "_valid"}, {127'd0, valid_o}, 128'd1);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_queue: got empty expected-word queue expected a word", name);
    end else begin
      e = exp_q.pop_front();
      check({name, "_data"}, data_o, e);
    end
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    exp_count = exp_count + 16'd1;
    check({name, "_count"}, {112'd0, count_o}, {112'd0, exp_count});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready_low", {127'd0, byte_ready_o}, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    exp_q.delete();
    exp_count = 16'd0;
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{8'h01, 8'h01, 128'h0102030405060708090a0b0c0d0e0f10};
    vecs[1] = '{8'hAA, 8'h00, 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa};
    vecs[2] = '{8'hF0, 8'h01, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff};
    vecs[3] = '{8'h80, 8'h10, 128'h8090a0b0c0d0e0f00010203040506070};
    vecs[4] = '{8'hFF, 8'hFF, 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0};

    rst = 1'b1; byte_i = 8'h00; byte_valid_i = 1'b0; abort_i = 1'b0; ack_i = 1'b0;
    @(negedge clk);
    do_reset();
    check("reset_ready", {127'd0, byte_ready_o}, 128'd1);
    check("reset_valid", {127'd0, valid_o}, 128'd0);
    check("reset_data", data_o, 128'd0);
    check("reset_count", {112'd0, count_o}, 128'd0);
    check("reset_overflow", {127'd0, overflow_o}, 128'd0);
    check("reset_state", {127'd0, dbg_state}, 128'd0);

    // Table-driven single words: valid rises right after the 16th byte.
    for (int v = 0; v < 5; v++) begin
      send_bytes(vecs[v].base, vecs[v].step, 15);
      check($sformatf("vec%0d_valid_before", v), {127'd0, valid_o}, 128'd0);
      send_byte(vecs[v].base + 8'(15) * vecs[v].step);
      check($sformatf("vec%0d_valid_after", v), {127'd0, valid_o}, 128'd1);
      check($sformatf("vec%0d_word", v), data_o, vecs[v].exp_word);
      exp_q.push_back(vecs[v].exp_word);
      ack_and_check($sformatf("vec%0d", v));
      check($sformatf("vec%0d_valid_cleared", v), {127'd0, valid_o}, 128'd0);
    end

    // Ack with the FIFO empty is ignored.
    ack_i = 1'b1;
    @(negedge clk);
    ack_i = 1'b0;
    @(negedge clk);
    check("empty_ack_count", {112'd0, count_o}, {112'd0, exp_count});
    check("empty_ack_valid", {127'd0, valid_o}, 128'd0);

    // Backpressure: 4 words fill the FIFO, only the 16th byte of word 5 stalls.
    for (int w = 0; w < 4; w++) send_word(8'h10 * 8'(w + 1), 8'h01);
    send_bytes(8'h50, 8'h01, 15);
    check("stall_ready", {127'd0, byte_ready_o}, 128'd0);
    check("stall_state", {127'd0, dbg_state}, 128'd1);
    ack_and_check("stall_pop0");
    check("stall_ready_after_pop", {127'd0, byte_ready_o}, 128'd1);
    check("stall_state_after_pop", {127'd0, dbg_state}, 128'd0);
    send_byte(8'h5F);
    exp_q.push_back(make_word(8'h50, 8'h01));
    check("stall_overflow_clear", {127'd0, overflow_o}, 128'd0);
    for (int w = 0; w < 4; w++) ack_and_check($sformatf("stall_order%0d", w));
    check("stall_drained", {127'd0, valid_o}, 128'd0);

    // The byte is offered while stalled together with a pop. It is dropped,
    // then accepted on the next cycle.
    for (int w = 0; w < 4; w++) send_word(8'h60 + 8'(w), 8'h02);
    send_bytes(8'hC0, 8'h01, 15);
    byte_i = 8'hCF;
    byte_valid_i = 1'b1;
    ack_i = 1'b1;
    exp_count = exp_count + 16'd1;
    void'(exp_q.pop_front());
    @(negedge clk);
    ack_i = 1'b0;
    check("ovf_set", {127'd0, overflow_o}, 128'd1);
    check("ovf_ready_reopened", {127'd0, byte_ready_o}, 128'd1);
    @(negedge clk);
    byte_valid_i = 1'b0;
    exp_q.push_back(make_word(8'hC0, 8'h01));
    for (int w = 0; w < 4; w++) ack_and_check($sformatf("ovf_order%0d", w));
    check("ovf_sticky", {127'd0, overflow_o}, 128'd1);
    check("ovf_drained", {127'd0, valid_o}, 128'd0);

    // Abort after 7 bytes. A byte presented in the abort cycle is dropped.
    send_bytes(8'h11, 8'h11, 7);
    abort_i = 1'b1;
    byte_i = 8'h55;
    byte_valid_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    byte_valid_i = 1'b0;
    send_word(8'hAA, 8'h00);
    check("abort_word", data_o, 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa);
    ack_and_check("abort");
    check("abort_one_word", {127'd0, valid_o}, 128'd0);

    // Reset with 3 words pending and 9 bytes into the next word.
    for (int w = 0; w < 3; w++) send_word(8'h21 * 8'(w + 1), 8'h03);
    send_bytes(8'h99, 8'h01, 9);
    do_reset();
    check("rst_valid", {127'd0, valid_o}, 128'd0);
    check("rst_count", {112'd0, count_o}, 128'd0);
    check("rst_overflow", {127'd0, overflow_o}, 128'd0);
    send_word(8'h01, 8'h01);
    check("post_rst_word", data_o, 128'h0102030405060708090a0b0c0d0e0f10);
    ack_and_check("post_rst");
    check("post_rst_count", {112'd0, count_o}, 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
